ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

Pipeline register and operand-selection stage sitting directly upstream of the execute-stage ALU. It accepts one decoded instruction per cycle from decode over a valid/ready handshake, holds it, and drives the ALU inputs `alu_a`, `alu_b`, `alu_operation_type` and `comparison_mode`. Before driving those inputs it resolves register operands by forwarding from the EX/MEM and MEM/WB stages. It also detects load-use hazards and inserts bubbles until the loaded data is available.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset; asynchronous assert, active-low.
- `flush` input 1: kill the held instruction and any instruction offered this cycle (branch/trap redirect).
- `id_valid` input 1: decode offers an instruction.
- `id_ready` output 1: stage can accept this cycle.
- `id_pc` input 32: instruction PC.
- `id_rs1_addr`, `id_rs2_addr` input 5: source register indices.
- `id_rs1_data`, `id_rs2_data` input 32: register-file read data.
- `id_imm` input 32: sign-extended immediate.
- `id_a_sel_pc` input 1: 1 = operand A is the PC, 0 = rs1.
- `id_b_sel_imm` input 1: 1 = operand B is the immediate, 0 = rs2.
- `id_alu_op` input 4: ALU operation code, passed through unchanged.
- `id_cmp_unsigned` input 1: comparison mode, 1 = unsigned.
- `id_rd_addr` input 5: destination register index.
- `exm_valid`, `exm_is_load` input 1: EX/MEM holds a valid instruction / that instruction is a load.
- `exm_rd_addr` input 5, `exm_rd_data` input 32: EX/MEM destination and result.
- `mwb_valid` input 1, `mwb_rd_addr` input 5, `mwb_rd_data` input 32: MEM/WB writeback.
- `ex_valid` output 1: ALU inputs are valid and hazard-free this cycle.
- `ex_ready` input 1: downstream consumes this cycle.
- `alu_a`, `alu_b` output 32: ALU operands.
- `alu_operation_type` output 4, `comparison_mode` output 1: ALU controls.
- `ex_pc` output 32, `ex_rd_addr` output 5, `ex_rs2_value` output 32: forwarded rs2 value, used for store data.

## Operation
- **Holding register.** Stores `held_valid` plus all `id_*` fields.
- **Accept.** `accept = id_valid & id_ready & ~flush`.
  - `id_ready = ~held_valid | (ex_valid & ex_ready)`.
- **Forwarding.** Applied per source register `rsN` held in the stage. `fwd_rsN` is chosen with this priority:
  1. If `rsN == 0`, the value is 0. x0 is never forwarded.
  2. Else, if `exm_valid & exm_rd_addr == rsN & ~exm_is_load`, use `exm_rd_data`.
  3. Else, if `mwb_valid & mwb_rd_addr == rsN`, use `mwb_rd_data`.
  4. Else, use the stored register data.
- **Load-use hazard.** `hazard = held_valid & exm_valid & exm_is_load & exm_rd_addr != 0` AND (`exm_rd_addr == rs1` with A selecting rs1, OR `exm_rd_addr == rs2`).
  - rs2 counts even when B selects the immediate, because it supplies store data.
  - `ex_valid = held_valid & ~hazard`.
- **Operand refresh.** While held and not consumed, stored rs1/rs2 data is overwritten each cycle with the MEM/WB value on a match. This prevents losing a writeback that retires while the stage stalls.
- **Operand select.**
  - `alu_a = id_a_sel_pc ? pc : fwd_rs1`.
  - `alu_b = id_b_sel_imm ? imm : fwd_rs2`.
  - `ex_rs2_value = fwd_rs2`.
- **Next-state priority**, highest first:
  1. `flush`: `held_valid` ← 0.
  2. `accept`: load new instruction.
  3. `ex_valid & ex_ready`: `held_valid` ← 0.
  4. Otherwise hold.
- **Flush.** Overrides a simultaneous accept or consume; `id_ready` is unaffected by `flush`.
- **Reset values.** All registers are 0; therefore `ex_valid` = 0, `alu_a` = `alu_b` = 0, `alu_operation_type` = 0, `comparison_mode` = 0, `ex_pc` = 0, `ex_rd_addr` = 0, `ex_rs2_value` = 0, and `id_ready` = 1.

## Timing
- **Latency.** Instruction accepted in cycle N appears with `ex_valid` = 1 in cycle N+1, absent a hazard.
- **Throughput.** One instruction per cycle when `ex_ready` is held high: consume and accept happen in the same cycle.
- **Outputs.** `alu_*` and `ex_valid` are combinational from the holding register and the forwarding inputs.
- **Handshake stability.** While `ex_valid & ~ex_ready`, the held fields are stable. Forwarded operands may still change only via refresh, which yields the same architectural value.
- **Hazard bubble.** A hazard lasts while the load sits in EX/MEM. With one cycle in MEM, the next cycle forwards from MEM/WB, giving one bubble.
- **Reset mid-operation.** Asynchronous; the held instruction is dropped immediately and outputs take their reset values.

## Test plan
- Reset with `id_valid` = 1 → `ex_valid` = 0 and `id_ready` = 1; first edge after release accepts the instruction and `ex_valid` = 1 next cycle.
- Back-to-back ADD x3 = x1 + x2, then x4 = x3 + x1, with `exm_rd_addr` = 3, `exm_rd_data` = 0x10 → `alu_a` = 0x10 (EX/MEM wins over MEM/WB x3 = 0x99).
- Held instruction reads x5 while `exm_is_load` = 1 and `exm_rd_addr` = 5 → `ex_valid` = 0 for one cycle; next cycle MEM/WB x5 = 0xDEAD → `alu_a` = 0xDEAD and `ex_valid` = 1.
- Instruction reads x0 while EX/MEM and MEM/WB both target rd = 0 with data 0xFFFF_FFFF → `alu_a` = 0.
- `ex_ready` = 0 for 3 cycles while MEM/WB writes x2 = 0x42 in the first stall cycle only → after release `alu_b` = 0x42, and `id_ready` stays 0 during the stall.
- `flush` asserted together with `id_valid` = 1 and `ex_ready` = 1 → next cycle `ex_valid` = 0 and nothing is captured; with `id_a_sel_pc` = 1, `id_b_sel_imm` = 1, pc = 0x100, imm = 4 → `alu_a` = 0x100, `alu_b` = 4, and `alu_operation_type` passes 4'b0010.

Source files
------------

// File: rtl/ex_operand_stage.sv
// Operand stage in front of the execute ALU: a one-deep holding register fed by decode,
// with EX/MEM and MEM/WB forwarding and load-use stall detection.
module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,

    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_a_sel_pc,
    input  logic            id_b_sel_imm,
    input  logic [3:0]      id_alu_op,
    input  logic            id_cmp_unsigned,
    input  logic [4:0]      id_rd_addr,

    input  logic            exm_valid,
    input  logic            exm_is_load,
    input  logic [4:0]      exm_rd_addr,
    input  logic [XLEN-1:0] exm_rd_data,

    input  logic            mwb_valid,
    input  logic [4:0]      mwb_rd_addr,
    input  logic [XLEN-1:0] mwb_rd_data,

    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_operation_type,
    output logic            comparison_mode,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd_addr,
    output logic [XLEN-1:0] ex_rs2_value
);

    logic            held_valid;
    logic [XLEN-1:0] held_pc;
    logic [4:0]      held_rs1_addr;
    logic [4:0]      held_rs2_addr;
    logic [XLEN-1:0] held_rs1_data;
    logic [XLEN-1:0] held_rs2_data;
    logic [XLEN-1:0] held_imm;
    logic            held_a_sel_pc;
    logic            held_b_sel_imm;
    logic [3:0]      held_alu_op;
    logic            held_cmp_unsigned;
    logic [4:0]      held_rd_addr;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            hazard;
    logic            consume;
    logic            accept;
    logic            refresh_rs1;
    logic            refresh_rs2;

    // EX/MEM results are newer than MEM/WB, but a load's EX/MEM value is only an address.
    function automatic logic [XLEN-1:0] fwd_value(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] value;
        if (addr == 5'd0)
            value = '0;
        else if (exm_valid && !exm_is_load && (exm_rd_addr == addr))
            value = exm_rd_data;
        else if (mwb_valid && (mwb_rd_addr == addr))
            value = mwb_rd_data;
        else
            value = stored;
        return value;
    endfunction

    always_comb begin
        fwd_rs1 = fwd_value(held_rs1_addr, held_rs1_data);
        fwd_rs2 = fwd_value(held_rs2_addr, held_rs2_data);
    end

    // rs2 is checked even for immediate forms because stores still need it as data.
    always_comb begin
        hazard = held_valid && exm_valid && exm_is_load && (exm_rd_addr != 5'd0) &&
                 (((exm_rd_addr == held_rs1_addr) && !held_a_sel_pc) ||
                  (exm_rd_addr == held_rs2_addr));
    end

    assign ex_valid    = held_valid && !hazard;
    assign consume     = ex_valid && ex_ready;
    assign id_ready    = !held_valid || consume;
    assign accept      = id_valid && id_ready && !flush;

    assign refresh_rs1 = mwb_valid && (mwb_rd_addr == held_rs1_addr) && (held_rs1_addr != 5'd0);
    assign refresh_rs2 = mwb_valid && (mwb_rd_addr == held_rs2_addr) && (held_rs2_addr != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid        <= 1'b0;
            held_pc           <= '0;
            held_rs1_addr     <= '0;
            held_rs2_addr     <= '0;
            held_rs1_data     <= '0;
            held_rs2_data     <= '0;
            held_imm          <= '0;
            held_a_sel_pc     <= 1'b0;
            held_b_sel_imm    <= 1'b0;
            held_alu_op       <= '0;
            held_cmp_unsigned <= 1'b0;
            held_rd_addr      <= '0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (accept) begin
            held_valid        <= 1'b1;
            held_pc           <= id_pc;
            held_rs1_addr     <= id_rs1_addr;
            held_rs2_addr     <= id_rs2_addr;
            held_rs1_data     <= id_rs1_data;
            held_rs2_data     <= id_rs2_data;
            held_imm          <= id_imm;
            held_a_sel_pc     <= id_a_sel_pc;
            held_b_sel_imm    <= id_b_sel_imm;
            held_alu_op       <= id_alu_op;
            held_cmp_unsigned <= id_cmp_unsigned;
            held_rd_addr      <= id_rd_addr;
        end else if (consume) begin
            held_valid <= 1'b0;
        end else if (held_valid) begin
            // Capture writebacks that retire during a stall so they are not lost.
            if (refresh_rs1)
                held_rs1_data <= mwb_rd_data;
            if (refresh_rs2)
                held_rs2_data <= mwb_rd_data;
        end
    end

    assign alu_a              = held_a_sel_pc  ? held_pc  : fwd_rs1;
    assign alu_b              = held_b_sel_imm ? held_imm : fwd_rs2;
    assign alu_operation_type = held_alu_op;
    assign comparison_mode    = held_cmp_unsigned;
    assign ex_pc              = held_pc;
    assign ex_rd_addr         = held_rd_addr;
    assign ex_rs2_value       = fwd_rs2;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, forwarding priority, load-use bubble,
// x0 handling, stall refresh, flush and asynchronous reset.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic        id_a_sel_pc;
    logic        id_b_sel_imm;
    logic [3:0]  id_alu_op;
    logic        id_cmp_unsigned;
    logic [4:0]  id_rd_addr;
    logic        exm_valid;
    logic        exm_is_load;
    logic [4:0]  exm_rd_addr;
    logic [31:0] exm_rd_data;
    logic        mwb_valid;
    logic [4:0]  mwb_rd_addr;
    logic [31:0] mwb_rd_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_operation_type;
    logic        comparison_mode;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_rs2_value;

    int checks = 0;
    int errors = 0;

    ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_a_sel_pc(id_a_sel_pc), .id_b_sel_imm(id_b_sel_imm),
        .id_alu_op(id_alu_op), .id_cmp_unsigned(id_cmp_unsigned), .id_rd_addr(id_rd_addr),
        .exm_valid(exm_valid), .exm_is_load(exm_is_load),
        .exm_rd_addr(exm_rd_addr), .exm_rd_data(exm_rd_data),
        .mwb_valid(mwb_valid), .mwb_rd_addr(mwb_rd_addr), .mwb_rd_data(mwb_rd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_operation_type(alu_operation_type), .comparison_mode(comparison_mode),
        .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_rs2_value(ex_rs2_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; checks run 1 ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [31:0] rs1d,
                          input logic [4:0] rs2, input logic [31:0] rs2d,
                          input logic [31:0] imm, input logic asel, input logic bsel,
                          input logic [3:0] op, input logic cmpu, input logic [4:0] rd);
        id_valid = v;        id_pc = pc;
        id_rs1_addr = rs1;   id_rs1_data = rs1d;
        id_rs2_addr = rs2;   id_rs2_data = rs2d;
        id_imm = imm;        id_a_sel_pc = asel;  id_b_sel_imm = bsel;
        id_alu_op = op;      id_cmp_unsigned = cmpu;  id_rd_addr = rd;
    endtask

    task automatic clear_fwd();
        exm_valid = 0; exm_is_load = 0; exm_rd_addr = 0; exm_rd_data = 0;
        mwb_valid = 0; mwb_rd_addr = 0; mwb_rd_data = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; ex_ready = 0;
        clear_fwd();
        set_id(1, 32'h40, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 0, 0, 4'h0, 0, 5'd3);
        tick();
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0b want 0", ex_valid); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got %0b want 1", id_ready); end
        checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin errors++; $display("FAIL reset_alu got a=%h b=%h want 0/0", alu_a, alu_b); end
        checks++; if (alu_operation_type !== 4'h0 || comparison_mode !== 1'b0 || ex_pc !== 32'h0 || ex_rd_addr !== 5'd0 || ex_rs2_value !== 32'h0) begin
            errors++; $display("FAIL reset_fields got op=%h cmp=%b pc=%h rd=%0d rs2v=%h want all 0", alu_operation_type, comparison_mode, ex_pc, ex_rd_addr, ex_rs2_value); end
        rst_n = 1;
        tick();
        id_valid = 0;
        #1;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL first_accept_valid got %0b want 1", ex_valid); end
        checks++; if (alu_a !== 32'h11 || alu_b !== 32'h22 || ex_pc !== 32'h40 || ex_rd_addr !== 5'd3) begin
            errors++; $display("FAIL first_accept_fields got a=%h b=%h pc=%h rd=%0d want 11/22/40/3", alu_a, alu_b, ex_pc, ex_rd_addr); end
    endtask

    task automatic test_back_to_back();
        ex_ready = 1;
        set_id(1, 32'h44, 5'd1, 32'h5, 5'd2, 32'h6, 32'h0, 0, 0, 4'h0, 0, 5'd3);
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_id_ready got %0b want 1", id_ready); end
        tick();
        set_id(1, 32'h48, 5'd3, 32'h0, 5'd1, 32'h5, 32'h0, 0, 0, 4'h0, 0, 5'd4);
        #1;
        checks++; if (ex_valid !== 1'b1 || alu_a !== 32'h5 || alu_b !== 32'h6 || ex_rd_addr !== 5'd3) begin
            errors++; $display("FAIL b2b_first got v=%0b a=%h b=%h rd=%0d want 1/5/6/3", ex_valid, alu_a, alu_b, ex_rd_addr); end
        tick();
        id_valid = 0;
        exm_valid = 1; exm_is_load = 0; exm_rd_addr = 5'd3; exm_rd_data = 32'h10;
        mwb_valid = 1; mwb_rd_addr = 5'd3; mwb_rd_data = 32'h99;
        #1;
        checks++; if (alu_a !== 32'h10 || alu_b !== 32'h5 || ex_rd_addr !== 5'd4) begin
            errors++; $display("FAIL fwd_exm_priority got a=%h b=%h rd=%0d want 10/5/4", alu_a, alu_b, ex_rd_addr); end
        exm_valid = 0;
        #1;
        checks++; if (alu_a !== 32'h99) begin errors++; $display("FAIL fwd_mwb got %h want 99", alu_a); end
        exm_valid = 1; exm_rd_addr = 5'd7;
        #1;
        checks++; if (alu_a !== 32'h99) begin errors++; $display("FAIL fwd_exm_other_rd got %h want 99", alu_a); end
        clear_fwd();
        #1;
        checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL fwd_none got %h want 0", alu_a); end
        tick();
    endtask

    task automatic test_load_use();
        set_id(1, 32'h50, 5'd5, 32'h1, 5'd6, 32'h66, 32'h0, 0, 0, 4'h0, 0, 5'd7);
        tick();
        id_valid = 0;
        exm_valid = 1; exm_is_load = 1; exm_rd_addr = 5'd5; exm_rd_data = 32'hBAD;
        #1;
        checks++; if (ex_valid !== 1'b0 || id_ready !== 1'b0) begin
            errors++; $display("FAIL load_use_bubble got v=%0b rdy=%0b want 0/0", ex_valid, id_ready); end
        tick();
        clear_fwd();
        mwb_valid = 1; mwb_rd_addr = 5'd5; mwb_rd_data = 32'hDEAD;
        #1;
        checks++; if (ex_valid !== 1'b1 || alu_a !== 32'hDEAD || alu_b !== 32'h66 || ex_pc !== 32'h50) begin
            errors++; $display("FAIL load_use_release got v=%0b a=%h b=%h pc=%h want 1/dead/66/50", ex_valid, alu_a, alu_b, ex_pc); end
        tick();
        clear_fwd();
        set_id(1, 32'h54, 5'd1, 32'h11, 5'd8, 32'h80, 32'h7, 0, 1, 4'h0, 0, 5'd0);
        tick();
        id_valid = 0;
        exm_valid = 1; exm_is_load = 1; exm_rd_addr = 5'd8;
        #1;
        checks++; if (ex_valid !== 1'b0 || alu_b !== 32'h7) begin
            errors++; $display("FAIL load_use_store_rs2 got v=%0b b=%h want 0/7", ex_valid, alu_b); end
        exm_valid = 0;
        #1;
        checks++; if (ex_valid !== 1'b1 || ex_rs2_value !== 32'h80) begin
            errors++; $display("FAIL store_rs2_value got v=%0b rs2v=%h want 1/80", ex_valid, ex_rs2_value); end
        tick();
        set_id(1, 32'h58, 5'd9, 32'h9, 5'd0, 32'h0, 32'h0, 1, 1, 4'h0, 0, 5'd1);
        tick();
        id_valid = 0;
        exm_valid = 1; exm_is_load = 1; exm_rd_addr = 5'd9;
        #1;
        checks++; if (ex_valid !== 1'b1 || alu_a !== 32'h58) begin
            errors++; $display("FAIL load_pc_operand_no_hazard got v=%0b a=%h want 1/58", ex_valid, alu_a); end
        clear_fwd();
        tick();
    endtask

    task automatic test_x0();
        set_id(1, 32'h60, 5'd0, 32'h123, 5'd0, 32'h456, 32'h0, 0, 0, 4'h1, 0, 5'd10);
        tick();
        id_valid = 0;
        exm_valid = 1; exm_is_load = 0; exm_rd_addr = 5'd0; exm_rd_data = 32'hFFFF_FFFF;
        mwb_valid = 1; mwb_rd_addr = 5'd0; mwb_rd_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || ex_valid !== 1'b1 || alu_operation_type !== 4'h1) begin
            errors++; $display("FAIL x0_never_forwarded got a=%h b=%h v=%0b op=%h want 0/0/1/1", alu_a, alu_b, ex_valid, alu_operation_type); end
        exm_is_load = 1;
        #1;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL x0_load_no_hazard got %0b want 1", ex_valid); end
        clear_fwd();
        tick();
    endtask

    task automatic test_stall_refresh();
        set_id(1, 32'h70, 5'd1, 32'h1, 5'd2, 32'h0, 32'h0, 0, 0, 4'h0, 0, 5'd9);
        tick();
        ex_ready = 0;
        set_id(1, 32'h74, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 0, 0, 4'h3, 0, 5'd11);
        mwb_valid = 1; mwb_rd_addr = 5'd2; mwb_rd_data = 32'h42;
        #1;
        checks++; if (id_ready !== 1'b0 || alu_b !== 32'h42) begin
            errors++; $display("FAIL stall1 got rdy=%0b b=%h want 0/42", id_ready, alu_b); end
        tick();
        mwb_valid = 0;
        #1;
        checks++; if (id_ready !== 1'b0 || alu_b !== 32'h42 || ex_pc !== 32'h70) begin
            errors++; $display("FAIL stall2_refresh got rdy=%0b b=%h pc=%h want 0/42/70", id_ready, alu_b, ex_pc); end
        tick();
        #1;
        checks++; if (id_ready !== 1'b0 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL stall3 got rdy=%0b v=%0b want 0/1", id_ready, ex_valid); end
        tick();
        ex_ready = 1;
        #1;
        checks++; if (alu_b !== 32'h42 || ex_valid !== 1'b1 || id_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release got b=%h v=%0b rdy=%0b want 42/1/1", alu_b, ex_valid, id_ready); end
        tick();
        #1;
        checks++; if (ex_pc !== 32'h74 || alu_operation_type !== 4'h3 || ex_rd_addr !== 5'd11) begin
            errors++; $display("FAIL stall_next_accept got pc=%h op=%h rd=%0d want 74/3/11", ex_pc, alu_operation_type, ex_rd_addr); end
    endtask

    task automatic test_flush();
        set_id(1, 32'h100, 5'd1, 32'h1, 5'd2, 32'h2, 32'h4, 1, 1, 4'b0010, 1, 5'd12);
        flush = 1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_id_ready got %0b want 1", id_ready); end
        tick();
        flush = 0;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_kills got %0b want 0", ex_valid); end
        tick();
        id_valid = 0;
        #1;
        checks++; if (ex_valid !== 1'b1 || alu_a !== 32'h100 || alu_b !== 32'h4 || alu_operation_type !== 4'b0010) begin
            errors++; $display("FAIL pc_imm_select got v=%0b a=%h b=%h op=%h want 1/100/4/2", ex_valid, alu_a, alu_b, alu_operation_type); end
        checks++; if (comparison_mode !== 1'b1 || ex_pc !== 32'h100 || ex_rs2_value !== 32'h2 || ex_rd_addr !== 5'd12) begin
            errors++; $display("FAIL pc_imm_fields got cmp=%b pc=%h rs2v=%h rd=%0d want 1/100/2/12", comparison_mode, ex_pc, ex_rs2_value, ex_rd_addr); end
    endtask

    task automatic test_async_reset();
        ex_ready = 0;
        #2;
        rst_n = 0;
        #1;
        checks++; if (ex_valid !== 1'b0 || id_ready !== 1'b1 || alu_a !== 32'h0 || alu_b !== 32'h0 || ex_pc !== 32'h0) begin
            errors++; $display("FAIL async_reset got v=%0b rdy=%0b a=%h b=%h pc=%h want 0/1/0/0/0", ex_valid, id_ready, alu_a, alu_b, ex_pc); end
        rst_n = 1;
        tick();
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL after_reset_idle got %0b want 0", ex_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0();
        test_stall_refresh();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
